ssd_min_sort: RTL

//  Receiving end of the PE SSD output (ssd_o / ssd_ovalid). Consumes one SSD
//  per candidate block position, tracks the minimum and its candidate index,
//  and presents the best match to the motion-vector stage with a valid/ready

---
 rtl/ssd_min_sort_if.sv | 37 +++
 rtl/ssd_min_sort.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/ssd_min_sort_if.sv
// rtl/ssd_min_sort_if.sv - SSD input stream and best-match result bundle (SSD_SORT_TOP2_EN adds second-best fields)
interface ssd_min_sort_if #(
    parameter int SSD_W = 20,
    parameter int IDX_W = 4
);
    logic [SSD_W-1:0] ssd_i;
    logic             ssd_ivalid;
    logic             ssd_ready;
    logic             blk_start;
    logic [SSD_W-1:0] best_ssd;
    logic [IDX_W-1:0] best_idx;
    logic             best_vld;
    logic             best_rdy;
    logic             busy;
`ifdef SSD_SORT_TOP2_EN
    logic [SSD_W-1:0] second_ssd;
    logic [IDX_W-1:0] second_idx;

    modport slave (
        input  ssd_i, ssd_ivalid, blk_start, best_rdy,
        output ssd_ready, best_ssd, best_idx, best_vld, busy, second_ssd, second_idx
    );
    modport master (
        output ssd_i, ssd_ivalid, blk_start, best_rdy,
        input  ssd_ready, best_ssd, best_idx, best_vld, busy, second_ssd, second_idx
    );
`else
    modport slave (
        input  ssd_i, ssd_ivalid, blk_start, best_rdy,
        output ssd_ready, best_ssd, best_idx, best_vld, busy
    );
    modport master (
        output ssd_i, ssd_ivalid, blk_start, best_rdy,
        input  ssd_ready, best_ssd, best_idx, best_vld, busy
    );
`endif
endinterface

// File: rtl/ssd_min_sort.sv
// rtl/ssd_min_sort.sv - per-block minimum SSD tracker with result handshake (optional SSD_SORT_TOP2_EN second-best)
module ssd_min_sort #(
    parameter int SSD_W    = 20,
    parameter int NUM_CAND = 16,
    parameter int IDX_W    = $clog2(NUM_CAND)
) (
    input  logic          clk,
    input  logic          rst,
    ssd_min_sort_if.slave bus
);
    localparam logic [SSD_W-1:0] ALL_ONES = '1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CAND - 1);

    typedef enum logic [1:0] {IDLE, SCAN, HOLD} state_t;

    state_t           state_q, state_d;
    logic [SSD_W-1:0] min_q, min_d;
    logic [IDX_W-1:0] min_idx_q, min_idx_d;
    logic [IDX_W-1:0] cnt_q, cnt_d;
    logic [SSD_W-1:0] best_ssd_q, best_ssd_d;
    logic [IDX_W-1:0] best_idx_q, best_idx_d;
    logic             best_vld_q, best_vld_d;
    logic             lt_min;
    assign lt_min = bus.ssd_i < min_q;

`ifdef SSD_SORT_TOP2_EN
    logic [SSD_W-1:0] sec_q, sec_d;
    logic [IDX_W-1:0] sec_idx_q, sec_idx_d;
    logic             lt_sec;
    assign lt_sec = bus.ssd_i < sec_q;
`endif

    // State register and all datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            min_q      <= ALL_ONES;
            min_idx_q  <= '0;
            cnt_q      <= '0;
            best_ssd_q <= '0;
            best_idx_q <= '0;
            best_vld_q <= 1'b0;
`ifdef SSD_SORT_TOP2_EN
            sec_q      <= ALL_ONES;
            sec_idx_q  <= '0;
`endif
        end else begin
            state_q    <= state_d;
            min_q      <= min_d;
            min_idx_q  <= min_idx_d;
            cnt_q      <= cnt_d;
            best_ssd_q <= best_ssd_d;
            best_idx_q <= best_idx_d;
            best_vld_q <= best_vld_d;
`ifdef SSD_SORT_TOP2_EN
            sec_q      <= sec_d;
            sec_idx_q  <= sec_idx_d;
`endif
        end
    end

    // Next-state and running min/second update for each accepted sample
    always_comb begin
        state_d    = state_q;
        min_d      = min_q;
        min_idx_d  = min_idx_q;
        cnt_d      = cnt_q;
        best_ssd_d = best_ssd_q;
        best_idx_d = best_idx_q;
        best_vld_d = best_vld_q;
`ifdef SSD_SORT_TOP2_EN
        sec_d      = sec_q;
        sec_idx_d  = sec_idx_q;
`endif
        case (state_q)
            IDLE: begin
                // blk_start alone means nothing here; a sample opens the block
                if (bus.ssd_ivalid) begin
                    min_d     = bus.ssd_i;
                    min_idx_d = '0;
                    cnt_d     = IDX_W'(1);
                    state_d   = SCAN;
`ifdef SSD_SORT_TOP2_EN
                    sec_d     = ALL_ONES;
                    sec_idx_d = '0;
`endif
                end
            end
            SCAN: begin
                if (bus.blk_start) begin
                    // Restart: a coincident sample becomes candidate 0
                    min_d     = bus.ssd_ivalid ? bus.ssd_i : ALL_ONES;
                    min_idx_d = '0;
                    cnt_d     = bus.ssd_ivalid ? IDX_W'(1) : '0;
`ifdef SSD_SORT_TOP2_EN
                    sec_d     = ALL_ONES;
                    sec_idx_d = '0;
`endif
                end else if (bus.ssd_ivalid) begin
                    // Strict compares so ties keep the earlier candidate
                    if (lt_min) begin
                        min_d     = bus.ssd_i;
                        min_idx_d = cnt_q;
`ifdef SSD_SORT_TOP2_EN
                        sec_d     = min_q;
                        sec_idx_d = min_idx_q;
`endif
                    end
`ifdef SSD_SORT_TOP2_EN
                    else if (lt_sec) begin
                        sec_d     = bus.ssd_i;
                        sec_idx_d = cnt_q;
                    end
`endif
                    cnt_d = cnt_q + IDX_W'(1);
                    if (cnt_q == LAST_IDX) begin
                        state_d    = HOLD;
                        cnt_d      = '0;
                        best_ssd_d = min_d;
                        best_idx_d = min_idx_d;
                        best_vld_d = 1'b1;
                    end
                end
            end
            HOLD: begin
                // Result must drain; blk_start and samples are ignored
                if (bus.best_rdy) begin
                    best_vld_d = 1'b0;
                    min_d      = ALL_ONES;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.ssd_ready = (state_q != HOLD);
    assign bus.busy      = (state_q == SCAN);
    assign bus.best_ssd  = best_ssd_q;
    assign bus.best_idx  = best_idx_q;
    assign bus.best_vld  = best_vld_q;
`ifdef SSD_SORT_TOP2_EN
    assign bus.second_ssd = sec_q;
    assign bus.second_idx = sec_idx_q;
`endif
endmodule
